// File: rtl/character_plane_writer.sv
// Write-side front end for the character plane: turns a handshaked byte stream into
// single-cycle cell writes, keeps the text cursor, and runs the full-plane blank sweep.
module character_plane_writer #(
  parameter int unsigned ROWS           = 16,
  parameter int unsigned COLS           = 40,
  parameter logic [7:0]  BLANK          = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] wr_char_id,
  output logic [3:0] wr_row,
  output logic [5:0] wr_col,
  output logic       wr_en,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col,
  output logic       busy
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [5:0] COL_LAST = 6'(COLS - 1);

  state_e     state_q, state_d;
  logic [3:0] cur_row_q, cur_row_d;
  logic [5:0] cur_col_q, cur_col_d;
  logic [3:0] swp_row_q, swp_row_d;
  logic [5:0] swp_col_q, swp_col_d;
  logic [7:0] wr_char_id_q, wr_char_id_d;
  logic [3:0] wr_row_q, wr_row_d;
  logic [5:0] wr_col_q, wr_col_d;
  logic       wr_en_q, wr_en_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      swp_row_q    <= '0;
      swp_col_q    <= '0;
      wr_char_id_q <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      swp_row_q    <= swp_row_d;
      swp_col_q    <= swp_col_d;
      wr_char_id_q <= wr_char_id_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_en_q      <= wr_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    swp_row_d    = swp_row_q;
    swp_col_d    = swp_col_q;
    wr_char_id_d = wr_char_id_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_en_d      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        wr_en_d      = 1'b1;
        wr_char_id_d = BLANK;
        wr_row_d     = swp_row_q;
        wr_col_d     = swp_col_q;
        cur_row_d    = '0;
        cur_col_d    = '0;
        if (swp_col_q == COL_LAST) begin
          swp_col_d = '0;
          if (swp_row_q == ROW_LAST) begin
            swp_row_d = '0;
            state_d   = IDLE;
          end else begin
            swp_row_d = swp_row_q + 4'd1;
          end
        end else begin
          swp_col_d = swp_col_q + 6'd1;
        end
      end
      IDLE: begin
        if (char_valid) begin
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            wr_en_d      = 1'b1;
            wr_char_id_d = char_data;
            wr_row_d     = cur_row_q;
            wr_col_d     = cur_col_q;
            if (cur_col_q == COL_LAST) begin
              cur_col_d = '0;
              cur_row_d = (cur_row_q == ROW_LAST) ? 4'd0 : cur_row_q + 4'd1;
            end else begin
              cur_col_d = cur_col_q + 6'd1;
            end
          end else begin
            unique case (char_data)
              8'h08: begin
                // Backspace at home does nothing; otherwise step back, then blank the new cell.
                if (cur_col_q != 6'd0 || cur_row_q != 4'd0) begin
                  if (cur_col_q == 6'd0) begin
                    cur_row_d = cur_row_q - 4'd1;
                    cur_col_d = COL_LAST;
                  end else begin
                    cur_col_d = cur_col_q - 6'd1;
                  end
                  wr_en_d      = 1'b1;
                  wr_char_id_d = BLANK;
                  wr_row_d     = cur_row_d;
                  wr_col_d     = cur_col_d;
                end
              end
              8'h0A: begin
                cur_col_d = '0;
                cur_row_d = (cur_row_q == ROW_LAST) ? 4'd0 : cur_row_q + 4'd1;
              end
              8'h0D: cur_col_d = '0;
              8'h0C: begin
                state_d   = CLEAR;
                swp_row_d = '0;
                swp_col_d = '0;
                cur_row_d = '0;
                cur_col_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    char_ready = (state_q == IDLE);
    busy       = (state_q == CLEAR);
  end

  assign wr_char_id = wr_char_id_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_en      = wr_en_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;

endmodule

// File: tb/tb_character_plane_writer.sv
// Directed bench for character_plane_writer: reset sweep, text, wrap, backspace,
// control codes, form feed and reset during a sweep.
module tb_character_plane_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] char_data = '0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] wr_char_id;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic       wr_en;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  character_plane_writer #(
    .ROWS(16), .COLS(40), .BLANK(8'h20), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .wr_char_id(wr_char_id), .wr_row(wr_row),
    .wr_col(wr_col), .wr_en(wr_en), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] id, input logic [3:0] r,
                        input logic [5:0] c);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, ".id"}, 32'(wr_char_id), 32'(id));
    chk({tag, ".row"}, 32'(wr_row), 32'(r));
    chk({tag, ".col"}, 32'(wr_col), 32'(c));
  endtask

  task automatic chk_cur(input string tag, input logic [3:0] r, input logic [5:0] c);
    chk({tag, ".crow"}, 32'(cursor_row), 32'(r));
    chk({tag, ".ccol"}, 32'(cursor_col), 32'(c));
  endtask

  // Drives one code for one edge, then samples #1 after the edge; valid stays high.
  task automatic send(input logic [7:0] code);
    char_data  = code;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input logic [7:0] code, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send(code);
    char_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    char_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Counts one run of consecutive sweep writes after the current point.
  task automatic sweep_check(input string tag);
    int unsigned cnt = 0, bad_id = 0, cycles = 0;
    logic [3:0] r0 = '1, r40 = '1, rl = '1;
    logic [5:0] c0 = '1, c40 = '1, cl = '1;
    while (cycles < 800) begin
      @(posedge clk);
      #1;
      cycles++;
      if (wr_en) begin
        cnt++;
        if (wr_char_id !== 8'h20) bad_id++;
        if (cnt == 1)  begin r0 = wr_row;  c0 = wr_col;  end
        if (cnt == 41) begin r40 = wr_row; c40 = wr_col; end
        rl = wr_row;
        cl = wr_col;
      end else if (cnt > 0) break;
    end
    chk({tag, ".count"}, cnt, 32'd640);
    chk({tag, ".bad_id"}, bad_id, 32'd0);
    chk({tag, ".first_row"}, 32'(r0), 32'd0);
    chk({tag, ".first_col"}, 32'(c0), 32'd0);
    chk({tag, ".w41_row"}, 32'(r40), 32'd1);
    chk({tag, ".w41_col"}, 32'(c40), 32'd0);
    chk({tag, ".last_row"}, 32'(rl), 32'd15);
    chk({tag, ".last_col"}, 32'(cl), 32'd39);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".ready"}, 32'(char_ready), 32'd1);
    chk_cur(tag, 4'd0, 6'd0);
  endtask

  initial begin
    int unsigned cnt;
    #2 reset = 1'b1;
    #1;
    chk("rst.wr_en", 32'(wr_en), 32'd0);
    chk("rst.id", 32'(wr_char_id), 32'd0);
    chk("rst.row", 32'(wr_row), 32'd0);
    chk("rst.col", 32'(wr_col), 32'd0);
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.ready", 32'(char_ready), 32'd0);
    chk_cur("rst", 4'd0, 6'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    sweep_check("sweep0");

    send(8'h48);
    chk_wr("txt.H", 8'h48, 4'd0, 6'd0);
    chk_cur("txt.H", 4'd0, 6'd1);
    send(8'h49);
    chk_wr("txt.I", 8'h49, 4'd0, 6'd1);
    chk_cur("txt.I", 4'd0, 6'd2);
    idle_cycle();
    chk("txt.idle_wr_en", 32'(wr_en), 32'd0);

    send(8'h0D);
    chk("cr0.wr_en", 32'(wr_en), 32'd0);
    chk_cur("cr0", 4'd0, 6'd0);
    send_n(8'h0A, 15);
    send_n(8'h41, 39);
    idle_cycle();
    chk_cur("pre_wrap15", 4'd15, 6'd39);
    send(8'h41);
    chk_wr("wrap15", 8'h41, 4'd15, 6'd39);
    chk_cur("wrap15", 4'd0, 6'd0);

    send(8'h08);
    chk("bs_home.wr_en", 32'(wr_en), 32'd0);
    chk_cur("bs_home", 4'd0, 6'd0);

    send_n(8'h0A, 3);
    send_n(8'h41, 39);
    send(8'h41);
    chk_wr("wrap3", 8'h41, 4'd3, 6'd39);
    chk_cur("wrap3", 4'd4, 6'd0);

    send_n(8'h0A, 14);
    idle_cycle();
    chk_cur("pre_bs", 4'd2, 6'd0);
    send(8'h08);
    chk_wr("bs_row", 8'h20, 4'd1, 6'd39);
    chk_cur("bs_row", 4'd1, 6'd39);

    send(8'h0D);
    send_n(8'h0A, 4);
    send_n(8'h42, 17);
    idle_cycle();
    chk_cur("pre_ctl", 4'd5, 6'd17);
    send(8'h0D);
    chk("ctl.cr.wr_en", 32'(wr_en), 32'd0);
    chk_cur("ctl.cr", 4'd5, 6'd0);
    send(8'h0A);
    chk("ctl.lf.wr_en", 32'(wr_en), 32'd0);
    chk_cur("ctl.lf", 4'd6, 6'd0);
    send(8'h07);
    chk("ctl.bel.wr_en", 32'(wr_en), 32'd0);
    chk("ctl.bel.ready", 32'(char_ready), 32'd1);
    chk_cur("ctl.bel", 4'd6, 6'd0);
    send(8'h7E);
    chk_wr("ctl.7e", 8'h7E, 4'd6, 6'd0);
    chk_cur("ctl.7e", 4'd6, 6'd1);
    send(8'h7F);
    chk("ctl.7f.wr_en", 32'(wr_en), 32'd0);
    send(8'h1F);
    chk("ctl.1f.wr_en", 32'(wr_en), 32'd0);
    chk_cur("ctl.1f", 4'd6, 6'd1);

    send(8'h0C);
    char_valid = 1'b0;
    chk("ff.ready", 32'(char_ready), 32'd0);
    chk("ff.busy", 32'(busy), 32'd1);
    chk("ff.wr_en", 32'(wr_en), 32'd0);
    chk_cur("ff", 4'd0, 6'd0);
    cnt = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (wr_en) cnt++;
      if (cnt == 100) break;
    end
    chk("ff.w100_count", cnt, 32'd100);
    chk("ff.w100_row", 32'(wr_row), 32'd2);
    chk("ff.w100_col", 32'(wr_col), 32'd19);
    reset = 1'b1;
    #1;
    chk("midrst.wr_en", 32'(wr_en), 32'd0);
    chk("midrst.row", 32'(wr_row), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    sweep_check("sweep1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/character_plane_writer.md
Name: character_plane_writer

Overview:
Write-side front end for the 16x40 character plane. It accepts a byte stream of character codes over a valid/ready handshake and keeps a text cursor. It turns printable codes and control codes into single-cycle writes on the plane's write port: character id, row, column and write enable. It also runs a full-plane blank sweep after reset and on form feed. The display scan keeps using the plane's read port; this block is the only writer.

Parameters:
ROWS, 16, number of text rows; must fit in 4 bits.
COLS, 40, number of text columns; must fit in 6 bits.
BLANK, 8'h20, character id written by clear, backspace and sweep.
CLEAR_ON_RESET, 1, if 1 the block enters CLEAR on reset; if 0 it enters IDLE.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
char_data  input  8  incoming character code
char_valid  input  1  char_data is valid this cycle
char_ready  output  1  block can accept a code this cycle
wr_char_id  output  8  character id to the plane write port
wr_row  output  4  write row
wr_col  output  6  write column
wr_en  output  1  plane write strobe, one cycle per cell
cursor_row  output  4  current cursor row
cursor_col  output  6  current cursor column
busy  output  1  high while the sweep is in progress

Behaviour:
- Reset (asynchronous, active-high):
  - wr_en=0, wr_char_id=0, wr_row=0, wr_col=0.
  - cursor=(0,0), sweep counters=(0,0).
  - state=CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Reset asserted mid-sweep aborts the sweep. After release the sweep restarts from (0,0).
- char_ready = (state==IDLE), combinational. busy = (state==CLEAR), combinational.
- A code is accepted on a rising edge with char_valid & char_ready. One code per cycle is sustainable.
- All wr_* outputs are registered. A write appears on wr_* in the cycle after the accepting edge and lasts exactly one cycle. wr_en=0 in any cycle with no accept and no sweep.
- Code handling, on the accepting edge:
  - 0x20..0x7E (printable): write (code, cursor).
    - Cursor advances col+1.
    - At col COLS-1: col wraps to 0 and row advances.
    - At row ROWS-1: row wraps to 0.
  - 0x08 (backspace): cursor moves back one cell, then write (BLANK, new cursor).
    - At col 0, row>0: new cursor is (row-1, COLS-1).
    - At (0,0): no write, cursor unchanged.
  - 0x0A (line feed): col=0, row=(row+1) mod ROWS. No write.
  - 0x0D (carriage return): col=0. No write.
  - 0x0C (form feed): state goes to CLEAR with sweep counters at (0,0). No write from the code itself.
  - Any other code: accepted and discarded. No write, cursor unchanged.
- CLEAR state:
  - Every edge registers wr_en=1, wr_char_id=BLANK, wr_row/wr_col=sweep counters.
  - Counters advance in row-major order: col 0..COLS-1, then next row.
  - Cursor is held at (0,0) throughout the sweep.
  - The edge that issues (ROWS-1, COLS-1) moves state to IDLE. The sweep is exactly ROWS*COLS = 640 writes.
  - char_valid is ignored during CLEAR; a held code is accepted at the first IDLE cycle.
- Cursor and counter arithmetic uses explicit compares against ROWS-1 and COLS-1, never natural binary overflow. Column values 40..63 and row values ≥ROWS are never produced.

Test Plan:
- Reset sweep: release reset with CLEAR_ON_RESET=1.
  - Expect wr_en high for exactly 640 consecutive cycles, wr_char_id=0x20.
  - First write is (0,0), 41st write is (1,0), last write is (15,39).
  - Then busy=0, char_ready=1, cursor=(0,0).
- Text write: send 'H'(0x48), 'I'(0x49) back-to-back.
  - Expect writes (0x48,0,0) then (0x49,0,1), each one cycle after its accept edge.
  - Cursor ends at (0,2).
- Wrap: with cursor at (15,39), send 0x41.
  - Expect write (0x41,15,39); cursor becomes (0,0).
  - Repeat with cursor at (3,39): cursor becomes (4,0).
- Backspace:
  - Cursor at (2,0), send 0x08: expect write (0x20,1,39), cursor (1,39).
  - Cursor at (0,0), send 0x08: no wr_en, cursor unchanged.
- Controls: cursor at (5,17).
  - Send 0x0D: cursor (5,0), no write.
  - Send 0x0A: cursor (6,0), no write.
  - Send 0x07: accepted, no write, cursor unchanged.
- Form feed and reset mid-sweep:
  - Send 0x0C: char_ready drops next cycle and 640 blank writes follow.
  - Assert reset after the 100th sweep write: wr_en=0 immediately (asynchronous).
  - After release: a full 640-write sweep restarts at (0,0).
